ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl_if.sv | 28 ++
 rtl/ram_fifo_ctrl.sv | 94 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Handshake and RAM-port bundle for ram_fifo_ctrl.
// The slave modport is the controller's view; master is the environment driving it.
interface ram_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_d;
  logic [DATA_WIDTH-1:0] ram_q;

  modport slave (
    input  in_valid, in_data, out_ready, ram_q,
    output in_ready, out_valid, out_data, count, ram_we, ram_addr, ram_d
  );

  modport master (
    output in_valid, in_data, out_ready, ram_q,
    input  in_ready, out_valid, out_data, count, ram_we, ram_addr, ram_d
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over an external single-port RAM with a one-word output register.
// Optional macro RAM_FIFO_CTRL_BYPASS_EN loads pushes straight into the output register when the RAM is empty.
module ram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input logic            clk,
  input logic            rst_n,
  ram_fifo_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] RAM_FULL = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] ram_cnt_q, ram_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic out_free_c;
  logic ram_full_c;
  logic rd_c;
  logic wr_c;
  logic byp_c;

  // Cycle classification: READ has priority so the output register never starves.
  assign out_free_c = !out_valid_q || bus.out_ready;
  assign ram_full_c = (ram_cnt_q == RAM_FULL);
  assign rd_c       = rst_n && (ram_cnt_q != '0) && out_free_c;

`ifdef RAM_FIFO_CTRL_BYPASS_EN
  assign byp_c = rst_n && (ram_cnt_q == '0) && out_free_c && bus.in_valid;
`else
  assign byp_c = 1'b0;
`endif

  assign wr_c = rst_n && !rd_c && !byp_c && bus.in_valid && !ram_full_c;

  // Non-write cycles park the address on wr_ptr, the slot that never holds live data.
  assign bus.ram_we    = wr_c;
  assign bus.ram_addr  = !rst_n ? '0 : (rd_c ? rd_ptr_q : wr_ptr_q);
  assign bus.ram_d     = bus.in_data;
  assign bus.in_ready  = rst_n && !ram_full_c && !rd_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.count     = count_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (rd_c) begin
      out_data_d  = bus.ram_q;
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
      ram_cnt_d   = ram_cnt_q - ADDR_WIDTH'(1);
    end else if (byp_c) begin
      out_data_d  = bus.in_data;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (wr_c) begin
      wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
      ram_cnt_d = ram_cnt_q + ADDR_WIDTH'(1);
    end

    count_d = CNT_W'(ram_cnt_d) + CNT_W'(out_valid_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: directed vector table, fill/drain sequences,
// mid-stream reset and a randomized run against a queue reference and a poisoning RAM model.
module tb_ram_fifo_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 7;
  localparam int unsigned D  = 128;
  localparam logic [DW-1:0] POISON = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // RAM model: a non-write edge invalidates the addressed slot, reads of dead slots return poison
  logic [DW-1:0] mem [D];
  logic          vld [D];
  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_d;
      vld[bus.ram_addr] <= 1'b1;
    end else begin
      vld[bus.ram_addr] <= 1'b0;
    end
  end
  assign bus.ram_q = vld[bus.ram_addr] ? mem[bus.ram_addr] : POISON;

  typedef struct {
    logic          iv;
    logic          ordy;
    logic [DW-1:0] d;
    logic          exp_ir;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic          exp_ov;
    logic [DW-1:0] exp_data;
    logic [AW:0]   exp_cnt;
  } vec_t;

  vec_t vecs [6];
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock against the reference queue; called right at a negedge with inputs already driven
  task automatic cycle(output logic acc);
    logic pop;
    #1;
    acc = bus.in_valid & bus.in_ready;
    pop = bus.out_valid & bus.out_ready;
    if (bus.out_valid) begin
      if (q.size() == 0) chk("spurious_valid", 64'(1), 64'(0));
      else               chk("pop_data", 64'(bus.out_data), 64'(q[0]));
    end
    if (pop && q.size() != 0) void'(q.pop_front());
    if (acc) q.push_back(bus.in_data);
    @(posedge clk);
    #1;
    chk("count", 64'(bus.count), 64'(q.size()));
    chk("count_max", 64'(bus.count > 8'(D)), 64'(0));
    @(negedge clk);
  endtask

  // Asserts reset between edges, checks the async clear, releases, checks the idle state
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_ram_we", 64'(bus.ram_we), 64'(0));
    chk("rst_ram_addr", 64'(bus.ram_addr), 64'(0));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data   = '0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_count", 64'(bus.count), 64'(0));
    chk("post_out_valid", 64'(bus.out_valid), 64'(0));
    chk("post_in_ready", 64'(bus.in_ready), 64'(1));
    chk("post_ram_we", 64'(bus.ram_we), 64'(0));
    chk("post_ram_addr", 64'(bus.ram_addr), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    logic got;
    int next;
    int tries;
    logic [AW-1:0] fill_addr;

`ifdef RAM_FIFO_CTRL_BYPASS_EN
    vecs[0] = '{1'b1, 1'b0, 32'hA5, 1'b1, 1'b0, 7'd0, 1'b0, 32'h0,  8'd0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 7'd0, 1'b1, 32'hA5, 8'd1};
    vecs[2] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 7'd0, 1'b1, 32'hA5, 8'd1};
    vecs[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 7'd0, 1'b1, 32'hA5, 8'd1};
    vecs[4] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 7'd0, 1'b1, 32'hA5, 8'd1};
    vecs[5] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 7'd0, 1'b0, 32'h0,  8'd0};
    fill_addr = 7'd127;
`else
    vecs[0] = '{1'b1, 1'b0, 32'hA5, 1'b1, 1'b1, 7'd0, 1'b0, 32'h0,  8'd0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 7'd0, 1'b0, 32'h0,  8'd1};
    vecs[2] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 7'd1, 1'b1, 32'hA5, 8'd1};
    vecs[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 7'd1, 1'b1, 32'hA5, 8'd1};
    vecs[4] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 7'd1, 1'b1, 32'hA5, 8'd1};
    vecs[5] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 7'd1, 1'b0, 32'h0,  8'd0};
    fill_addr = 7'd0;
`endif
    for (int i = 0; i < int'(D); i++) vld[i] = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data   = '0;

    @(negedge clk);
    do_reset();

    // Single-word push and held output
    for (int i = 0; i < 6; i++) begin
      bus.in_valid  = vecs[i].iv;
      bus.out_ready = vecs[i].ordy;
      bus.in_data   = vecs[i].d;
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_ir));
      chk($sformatf("v%0d_ram_we", i), 64'(bus.ram_we), 64'(vecs[i].exp_we));
      chk($sformatf("v%0d_ram_addr", i), 64'(bus.ram_addr), 64'(vecs[i].exp_addr));
      chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_ov));
      chk($sformatf("v%0d_count", i), 64'(bus.count), 64'(vecs[i].exp_cnt));
      if (vecs[i].exp_ov) chk($sformatf("v%0d_out_data", i), 64'(bus.out_data), 64'(vecs[i].exp_data));
      @(negedge clk);
    end

    // Fill to D words with the consumer stalled
    do_reset();
    for (int w = 0; w < int'(D); w++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(w);
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 10) begin
        cycle(acc);
        tries++;
      end
      if (!acc) chk($sformatf("fill_timeout_w%0d", w), 64'(0), 64'(1));
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    #1;
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    chk("full_ram_we", 64'(bus.ram_we), 64'(0));
    chk("full_count", 64'(bus.count), 64'(D));
    chk("full_wr_ptr", 64'(bus.ram_addr), 64'(fill_addr));
    chk("full_head", 64'(bus.out_data), 64'(0));
    @(negedge clk);
    chk("full_hold_count", 64'(bus.count), 64'(D));

    // Drain from full while pushing continuously
    next = int'(D);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      bus.in_data = DW'(next);
      cycle(acc);
      if (acc) next++;
    end

    // Reset mid-stream at count 50, then the next push must be the first word out
    do_reset();
    bus.out_ready = 1'b0;
    tries = 0;
    while (q.size() < 50 && tries < 200) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      cycle(acc);
      tries++;
    end
    chk("pre_reset_count", 64'(bus.count), 64'(50));
    bus.out_ready = 1'b1;
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 5) begin
      cycle(acc);
      tries++;
    end
    chk("deadbeef_accepted", 64'(acc), 64'(1));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (bus.out_valid && !got) begin
        got = 1'b1;
        chk("first_after_reset", 64'(bus.out_data), 64'(32'hDEAD_BEEF));
      end
      cycle(acc);
    end
    if (!got) chk("first_after_reset_timeout", 64'(0), 64'(1));

    // Random traffic against the reference queue
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_data   = $urandom;
      cycle(acc);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tries = 0;
    while ((q.size() != 0 || bus.out_valid) && tries < 400) begin
      cycle(acc);
      tries++;
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
    chk("drain_out_valid", 64'(bus.out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
